xnor_compare_seq: RTL
=====================

XNOR_COMPARE_SEQ -- requirements
Module: xnor_compare_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, at least 1.
REQ-002 SHALL have parameter STEP, default 1: bits compared per cycle; WIDTH SHALL be a multiple of STEP.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to compare a and b.
REQ-006 SHALL have port a, input, WIDTH: first operand.
REQ-007 SHALL have port b, input, WIDTH: second operand.
REQ-008 SHALL have port busy, output, 1: comparison in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port eq, output, 1: all WIDTH bits matched.
REQ-011 SHALL have port match_vec, output, WIDTH: per-bit XNOR result.
REQ-012 SHALL have port match_cnt, output, clog2(WIDTH+1): number of matching bits.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 IDLE, start=1: SHALL latch a and b, clear match_vec, match_cnt and eq, and enter RUN.
REQ-015 SHALL not latch a or b at any other time.
REQ-016 Each RUN cycle SHALL process bit slice [i, i+STEP-1], starting at i=0 and increasing by STEP.
REQ-017 For each bit in the slice, SHALL set match_vec[i+k] = ~(a_latched[i+k] ^ b_latched[i+k]).
REQ-018 Each RUN cycle SHALL add the slice popcount to match_cnt.
REQ-019 After N = WIDTH/STEP RUN cycles, SHALL enter DONE.
REQ-020 DONE: done=1 for exactly one cycle; eq=1 iff match_cnt==WIDTH; next state IDLE.
REQ-021 Latency: start sampled at edge T0 -> done high in the cycle following edge T0+N+1.
REQ-022 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-023 SHALL ignore start while busy, with no restart and no operand change.
REQ-024 match_vec, match_cnt and eq SHALL hold their values in IDLE until the next accepted start.
REQ-025 match_cnt SHALL never exceed WIDTH, and SHALL not wrap.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE and set busy=0, done=0, eq=0, match_vec=0, match_cnt=0.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 reset asserted mid-RUN SHALL abort the comparison, with no done pulse.

Configuration
REQ-029 Macro XNOR_CMP_EARLY_EXIT_EN defined: a RUN cycle whose slice contains any mismatch SHALL be the last RUN cycle.
REQ-030 In that case, the next state SHALL be DONE with eq=0.
REQ-031 Unprocessed match_vec bits SHALL stay 0, and match_cnt SHALL count only processed bits.
REQ-032 Macro undefined: SHALL always run all N RUN cycles.

Structure
REQ-033 Package xnor_cmp_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH and STEP constants.
REQ-034 Sub-module xnor_slice SHALL compute a STEP-bit XNOR vector plus its popcount, combinationally.
REQ-035 xnor_compare_seq SHALL instantiate xnor_slice once.

Verification
REQ-036 WIDTH=8, STEP=1, a=8'hA5, b=8'hA5, start pulse -> done 9 cycles later; eq=1; match_vec=8'hFF; match_cnt=8.
REQ-037 a=8'hF0, b=8'hF1 -> match_vec=8'hFE, match_cnt=7, eq=0; with XNOR_CMP_EARLY_EXIT_EN: done after 1 RUN cycle, match_vec=0, match_cnt=0.
REQ-038 a=8'hA5, b=8'h5A -> match_vec=8'h00, match_cnt=0, eq=0.
REQ-039 start=1 with a=8'h00 while busy (3 cycles after the first start) -> result of the first comparison unchanged; a single done pulse.
REQ-040 reset asserted on cycle 4 of RUN -> next cycle busy=0, done stays 0, match_vec=0, match_cnt=0.
REQ-041 WIDTH=8, STEP=4, a=b=8'h3C -> done 3 cycles after start; eq=1; match_cnt=8.

Source files
------------

// File: rtl/xnor_cmp_pkg.sv
// Shared constants and FSM state encoding for the sequential XNOR comparator.
package xnor_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_STEP  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xnor_slice.sv
// Combinational STEP-bit XNOR of two slices, plus the popcount of the result.
module xnor_slice
  import xnor_cmp_pkg::*;
#(
  parameter  int STEP  = DEFAULT_STEP,
  localparam int CNT_W = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0]  i_a,
  input  logic [STEP-1:0]  i_b,
  output logic [STEP-1:0]  o_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // NOTE: every output gets a value before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_vec = ~(i_a ^ i_b);
    o_cnt = '0;
    for (int k = 0; k < STEP; k++) begin
      o_cnt = o_cnt + CNT_W'(o_vec[k]);
    end
  end

endmodule

// File: rtl/xnor_compare_seq.sv
// Sequential bit-wise XNOR comparator, STEP bits per cycle over a WIDTH-bit operand pair.
// Define XNOR_CMP_EARLY_EXIT_EN to stop at the first slice that contains a mismatch.
module xnor_compare_seq
  import xnor_cmp_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int STEP  = DEFAULT_STEP,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [WIDTH-1:0] match_vec,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SCNT_W = $clog2(STEP + 1);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_match_vec;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [CNT_W-1:0]   r_pos;
  logic               r_eq;
  logic [STEP-1:0]    w_slice_vec;
  logic [SCNT_W-1:0]  w_slice_cnt;
  logic               w_accept;
  logic               w_run_end;
  logic               w_slice_miss;

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_run_end    = (r_pos == CNT_W'(WIDTH));
  assign w_slice_miss = (w_slice_cnt != SCNT_W'(STEP));

  // Operand copies shift right each RUN cycle so the current slice always sits in the low bits.
  xnor_slice #(.STEP(STEP)) u_slice (
    .i_a   (r_a[STEP-1:0]),
    .i_b   (r_b[STEP-1:0]),
    .o_vec (w_slice_vec),
    .o_cnt (w_slice_cnt)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      // The extra RUN cycle after the last slice registers eq from the final count.
      ST_RUN: begin
        if (w_run_end) w_next = ST_DONE;
`ifdef XNOR_CMP_EARLY_EXIT_EN
        else if (w_slice_miss) w_next = ST_DONE;
`endif
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: operand copies carry no reset; they are only observed after a start reloads them.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_a <= a;
      r_b <= b;
    end else if (r_state == ST_RUN) begin
      r_a <= r_a >> STEP;
      r_b <= r_b >> STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_match_vec <= '0;
      r_match_cnt <= '0;
      r_pos       <= '0;
      r_eq        <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (!w_run_end) begin
        r_match_vec <= r_match_vec | (WIDTH'(w_slice_vec) << r_pos);
        r_match_cnt <= r_match_cnt + CNT_W'(w_slice_cnt);
        r_pos       <= r_pos + CNT_W'(STEP);
      end else begin
        r_eq <= (r_match_cnt == CNT_W'(WIDTH));
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign eq        = r_eq;
  assign match_vec = r_match_vec;
  assign match_cnt = r_match_cnt;

endmodule
